// File: rtl/wb_fifo_slave_if.sv
// Wishbone pipelined bus bundle shared by the FIFO mailbox slave and its master.
interface wb_fifo_slave_if #(
  parameter int WB_BUS_WIDTH  = 32,
  parameter int WB_ADDR_WIDTH = 32
);
  logic [WB_BUS_WIDTH-1:0]   wb_data_i;
  logic [WB_ADDR_WIDTH-1:0]  wb_addr_i;
  logic                      wb_cyc_i;
  logic                      wb_lock_i;
  logic [WB_BUS_WIDTH/8-1:0] wb_sel_i;
  logic                      wb_stb_i;
  logic                      wb_we_i;
  logic [WB_BUS_WIDTH-1:0]   wb_data_o;
  logic                      wb_ack_o;
  logic                      wb_stall_o;
  logic                      wb_err_o;
  logic                      wb_rty_o;

  modport slave (
    input  wb_data_i, wb_addr_i, wb_cyc_i, wb_lock_i, wb_sel_i, wb_stb_i, wb_we_i,
    output wb_data_o, wb_ack_o, wb_stall_o, wb_err_o, wb_rty_o
  );

  modport master (
    output wb_data_i, wb_addr_i, wb_cyc_i, wb_lock_i, wb_sel_i, wb_stb_i, wb_we_i,
    input  wb_data_o, wb_ack_o, wb_stall_o, wb_err_o, wb_rty_o
  );
endinterface

// File: rtl/wb_fifo_slave.sv
// Wishbone FIFO mailbox slave: DATA push/pop, STATUS, CONTROL registers.
// Define WB_FIFO_RTY_EN to answer full pushes / empty pops with retry instead of sticky errors.
module wb_fifo_slave #(
  parameter int                       WB_BUS_WIDTH    = 32,
  parameter int                       WB_ADDR_WIDTH   = 32,
  parameter logic [WB_ADDR_WIDTH-1:0] WB_BUS_ADDR     = 32'h0000_3000,
  parameter int                       FIFO_DEPTH_LOG2 = 2
) (
  input logic             wb_clk_i,
  input logic             wb_reset_i,
  wb_fifo_slave_if.slave  bus
);
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [WB_BUS_WIDTH/8-1:0] SEL_ALL = '1;
  localparam logic [FIFO_DEPTH_LOG2:0] FULL_COUNT = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};

  logic [WB_BUS_WIDTH-1:0]    mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr, wr_ptr;
  logic [FIFO_DEPTH_LOG2:0]   count;
  logic                       overflow, underflow;

  logic                    ack_q, err_q, rty_q;
  logic [WB_BUS_WIDTH-1:0] data_q;

  logic                    select, empty, full;
  logic [1:0]              offset;
  logic [WB_BUS_WIDTH-1:0] status;
  logic                    do_push, do_pop, do_flush, do_clear, set_ovf, set_udf;
  logic                    resp_ack, resp_err, resp_rty;
  logic [WB_BUS_WIDTH-1:0] resp_data;

  wire unused_bits = &{1'b0, bus.wb_lock_i, bus.wb_addr_i[1:0]};

  assign select = bus.wb_cyc_i & bus.wb_stb_i &
                  (bus.wb_addr_i[WB_ADDR_WIDTH-1:4] == WB_BUS_ADDR[WB_ADDR_WIDTH-1:4]);
  assign offset = bus.wb_addr_i[3:2];
  assign empty  = (count == '0);
  assign full   = (count == FULL_COUNT);

  always_comb begin
    status                    = '0;
    status[FIFO_DEPTH_LOG2:0] = count;
    status[16]                = empty;
    status[17]                = full;
    status[18]                = overflow;
    status[19]                = underflow;
  end

  // Decode the accepted request into side effects and the response to register.
  always_comb begin
    do_push   = 1'b0;
    do_pop    = 1'b0;
    do_flush  = 1'b0;
    do_clear  = 1'b0;
    set_ovf   = 1'b0;
    set_udf   = 1'b0;
    resp_ack  = 1'b0;
    resp_err  = 1'b0;
    resp_rty  = 1'b0;
    resp_data = '0;
    if (select) begin
      if (offset == 2'd3 || bus.wb_sel_i != SEL_ALL || (bus.wb_we_i && offset == 2'd1)) begin
        resp_err = 1'b1;
      end else begin
        case (offset)
          2'd0: begin
            if (bus.wb_we_i) begin
              if (full) begin
`ifdef WB_FIFO_RTY_EN
                resp_rty = 1'b1;
`else
                resp_ack = 1'b1;
                set_ovf  = 1'b1;
`endif
              end else begin
                resp_ack = 1'b1;
                do_push  = 1'b1;
              end
            end else begin
              if (empty) begin
`ifdef WB_FIFO_RTY_EN
                resp_rty = 1'b1;
`else
                resp_ack = 1'b1;
                set_udf  = 1'b1;
`endif
              end else begin
                resp_ack  = 1'b1;
                do_pop    = 1'b1;
                resp_data = mem[rd_ptr];
              end
            end
          end
          2'd1: begin
            resp_ack  = 1'b1;
            resp_data = status;
          end
          2'd2: begin
            resp_ack = 1'b1;
            if (bus.wb_we_i) begin
              do_flush = bus.wb_data_i[0];
              do_clear = bus.wb_data_i[1];
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_reset_i) begin
    if (wb_reset_i) begin
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rty_q     <= 1'b0;
      data_q    <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      ack_q  <= resp_ack;
      err_q  <= resp_err;
      rty_q  <= resp_rty;
      data_q <= resp_data;
      if (do_flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
        count  <= count + 1'b1;
      end else if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        count  <= count - 1'b1;
      end
      if (do_clear) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        if (set_ovf) overflow  <= 1'b1;
        if (set_udf) underflow <= 1'b1;
      end
    end
  end

  // Storage has no reset; only the pointers and count define what is valid.
  always_ff @(posedge wb_clk_i) begin
    if (do_push) mem[wr_ptr] <= bus.wb_data_i;
  end

  // Responses are gated so the OR-combined slave bus sees zeros when we are silent.
  assign bus.wb_ack_o   = ack_q & bus.wb_cyc_i;
  assign bus.wb_err_o   = err_q & bus.wb_cyc_i;
  assign bus.wb_rty_o   = rty_q & bus.wb_cyc_i;
  assign bus.wb_stall_o = 1'b0;
  assign bus.wb_data_o  = bus.wb_ack_o ? data_q : '0;
endmodule

// File: tb/tb_wb_fifo_slave.sv
// Scoreboard bench for wb_fifo_slave; expectations come from a queue model of the FIFO.
module tb_wb_fifo_slave;
  localparam logic [31:0] BASE  = 32'h0000_3000;
  localparam int          DEPTH = 4;

  logic clk;
  logic rst;
  wb_fifo_slave_if #(.WB_BUS_WIDTH(32), .WB_ADDR_WIDTH(32)) bus ();

  wb_fifo_slave #(
    .WB_BUS_WIDTH(32), .WB_ADDR_WIDTH(32), .WB_BUS_ADDR(BASE), .FIFO_DEPTH_LOG2(2)
  ) dut (
    .wb_clk_i   (clk),
    .wb_reset_i (rst),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] resp;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mq[$];
  bit          ovf, udf;
  int          tests, failures;
  logic        req_seen;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  function automatic logic [63:0] mkResp(input bit a, input bit e, input bit r, input logic [31:0] d);
    return {28'b0, a, e, r, 1'b0, d};
  endfunction

  function automatic logic [63:0] observed();
    return {28'b0, bus.wb_ack_o, bus.wb_err_o, bus.wb_rty_o, bus.wb_stall_o, bus.wb_data_o};
  endfunction

  // Drive one request for a single cycle; its expected response is queued now.
  task automatic applyStimulus(input logic [31:0] addr, input bit we, input logic [31:0] data,
                               input logic [3:0] sel, input logic [63:0] exp_resp, input string tag);
    exp_t e;
    e.resp = exp_resp;
    e.tag  = tag;
    sb.push_back(e);
    bus.wb_addr_i = addr;
    bus.wb_we_i   = we;
    bus.wb_data_i = data;
    bus.wb_sel_i  = sel;
    bus.wb_cyc_i  = 1'b1;
    bus.wb_stb_i  = 1'b1;
    @(posedge clk);
    #1;
    bus.wb_stb_i  = 1'b0;
    bus.wb_we_i   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic doPush(input logic [31:0] d);
    logic [63:0] r;
    if (mq.size() == DEPTH) begin
`ifdef WB_FIFO_RTY_EN
      r = mkResp(0, 0, 1, 0);
`else
      ovf = 1;
      r = mkResp(1, 0, 0, 0);
`endif
    end else begin
      mq.push_back(d);
      r = mkResp(1, 0, 0, 0);
    end
    applyStimulus(BASE, 1, d, 4'hF, r, "push");
  endtask

  task automatic doPop();
    logic [63:0] r;
    if (mq.size() == 0) begin
`ifdef WB_FIFO_RTY_EN
      r = mkResp(0, 0, 1, 0);
`else
      udf = 1;
      r = mkResp(1, 0, 0, 0);
`endif
    end else begin
      r = mkResp(1, 0, 0, mq.pop_front());
    end
    applyStimulus(BASE, 0, 32'h0, 4'hF, r, "pop");
  endtask

  task automatic readStatus();
    logic [31:0] s;
    s = '0;
    s[2:0] = 3'(mq.size());
    s[16]  = (mq.size() == 0);
    s[17]  = (mq.size() == DEPTH);
    s[18]  = ovf;
    s[19]  = udf;
    applyStimulus(BASE + 32'h4, 0, 32'h0, 4'hF, mkResp(1, 0, 0, s), "status");
  endtask

  task automatic writeControl(input logic [31:0] v);
    if (v[0]) mq.delete();
    if (v[1]) begin
      ovf = 0;
      udf = 0;
    end
    applyStimulus(BASE + 32'h8, 1, v, 4'hF, mkResp(1, 0, 0, 0), "control_wr");
  endtask

  // A selected request reaches the response edge as a scoreboard pop; otherwise outputs must be quiet.
  always @(posedge clk) req_seen <= bus.wb_cyc_i & bus.wb_stb_i & ~rst;

  always @(negedge clk) begin
    exp_t e;
    if (req_seen) begin
      if (sb.size() == 0) checkOutput("sb_underrun", 64'd1, 64'd0);
      else begin
        e = sb.pop_front();
        checkOutput(e.tag, observed(), e.resp);
      end
    end else begin
      checkOutput("idle", observed(), 64'd0);
    end
  end

  initial begin
    tests = 0;
    failures = 0;
    ovf = 0;
    udf = 0;
    bus.wb_addr_i = '0;
    bus.wb_data_i = '0;
    bus.wb_sel_i  = '0;
    bus.wb_we_i   = 1'b0;
    bus.wb_lock_i = 1'b0;
    bus.wb_cyc_i  = 1'b0;
    bus.wb_stb_i  = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", observed(), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.wb_cyc_i = 1'b1;
    idle(1);

    readStatus();
    doPush(32'hA1);
    doPush(32'hB2);
    doPush(32'hC3);
    doPush(32'hD4);
    readStatus();
    repeat (4) doPop();
    readStatus();

    for (int i = 0; i < 10; i++) begin
      doPush($urandom);
      doPop();
    end
    readStatus();

    for (int i = 0; i < 5; i++) doPush(32'h100 + 32'(i));
    readStatus();
    repeat (4) doPop();
    doPop();
    readStatus();

    applyStimulus(BASE + 32'hC, 0, 0, 4'hF, mkResp(0, 1, 0, 0), "err_reserved");
    applyStimulus(BASE + 32'h4, 1, 32'hFFFF_FFFF, 4'hF, mkResp(0, 1, 0, 0), "err_status_wr");
    applyStimulus(BASE, 1, 32'hDEAD, 4'b0011, mkResp(0, 1, 0, 0), "err_sel_wr");
    applyStimulus(BASE, 0, 0, 4'b0011, mkResp(0, 1, 0, 0), "err_sel_rd");
    applyStimulus(32'h2000, 1, 32'h55, 4'hF, 64'd0, "foreign_wr");
    applyStimulus(32'h2000, 0, 0, 4'hF, 64'd0, "foreign_rd");
    readStatus();

    doPush(32'h1111_2222);
    doPush(32'h3333_4444);
    writeControl(32'h3);
    readStatus();
    applyStimulus(BASE + 32'h8, 0, 0, 4'hF, mkResp(1, 0, 0, 0), "control_rd");

    // Dropping cyc in the response cycle hides the ack but keeps the push.
    mq.push_back(32'hCAFE_0001);
    applyStimulus(BASE, 1, 32'hCAFE_0001, 4'hF, 64'd0, "suppressed_push");
    bus.wb_cyc_i = 1'b0;
    idle(1);
    bus.wb_cyc_i = 1'b1;
    readStatus();
    doPop();

    // Reset while an ack is pending must swallow it and empty the FIFO.
    applyStimulus(BASE, 1, 32'hBEEF, 4'hF, 64'd0, "reset_pending");
    rst = 1'b1;
    mq.delete();
    ovf = 0;
    udf = 0;
    idle(2);
    rst = 1'b0;
    idle(1);
    readStatus();

    idle(3);
    checkOutput("sb_drain", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule

// File: doc/wb_fifo_slave.md
# wb_fifo_slave

Wishbone pipelined responder that exposes a word-wide FIFO mailbox to the bus master. It sits on the shared slave bus beside the LED slaves: the master pushes words through a DATA register, pops them back, and reads occupancy and sticky error flags through STATUS. Its outputs are OR-combined with the other slaves, so every output stays zero unless this slave is responding.

## Interface
- WB_BUS_WIDTH, 32: data bus width; fixed at 32 for this block.
- WB_ADDR_WIDTH, 32: byte address width.
- WB_BUS_ADDR, 32'h00003000: base address; must be 16-byte aligned.
- FIFO_DEPTH_LOG2, 2: log2 of FIFO depth in words (1..15).

- wb_clk_i  in  1  clock; all state on rising edge.
- wb_reset_i  in  1  asynchronous, active-high reset.
- wb_data_i  in  WB_BUS_WIDTH  write data.
- wb_addr_i  in  WB_ADDR_WIDTH  byte address.
- wb_cyc_i  in  1  bus cycle active.
- wb_lock_i  in  1  ignored.
- wb_sel_i  in  WB_BUS_WIDTH/8  byte selects.
- wb_stb_i  in  1  strobe.
- wb_we_i  in  1  write enable.
- wb_data_o  out  WB_BUS_WIDTH  read data; zero when wb_ack_o low.
- wb_ack_o  out  1  normal termination.
- wb_stall_o  out  1  always 0 (one request accepted per cycle).
- wb_err_o  out  1  error termination.
- wb_rty_o  out  1  retry termination.

## Operation
- Select: wb_cyc_i & wb_stb_i & (wb_addr_i[WB_ADDR_WIDTH-1:4] == WB_BUS_ADDR[WB_ADDR_WIDTH-1:4]). Unselected requests get no response.
- Offset wb_addr_i[3:2]: 0 DATA, 1 STATUS, 2 CONTROL, 3 reserved.
- Error: offset 3, or wb_sel_i not all ones, or write to STATUS -> wb_err_o, no side effect.
- DATA write: push wb_data_i; ack. DATA read: pop head; ack with head word.
- STATUS read: [FIFO_DEPTH_LOG2:0] count, [16] empty, [17] full, [18] overflow sticky, [19] underflow sticky, others 0.
- CONTROL write: bit0=1 flush (pointers and count to 0, stored words unspecified); bit1=1 clears both sticky flags. Both in one write allowed. CONTROL read returns 0.
- Storage: circular buffer, read/write pointers FIFO_DEPTH_LOG2 bits wrapping modulo depth; count FIFO_DEPTH_LOG2+1 bits, 0..2^FIFO_DEPTH_LOG2.
- Push when full / pop when empty: see Configuration.
- Side effects commit at the acceptance edge, never twice.

## Timing
- Reset: all outputs 0, pointers/count 0, stickies 0; any pending response discarded.
- Request accepted on the edge where select is true; exactly one of ack/err/rty asserted for exactly one cycle on the next cycle (latency 1). Back-to-back requests get back-to-back responses.
- Pop data registered at acceptance; wb_data_o valid only with wb_ack_o.
- Status read reflects state before the same-cycle access; after push, the next STATUS read sees the increment.
- If wb_cyc_i is low in the response cycle, the response is suppressed (outputs 0); committed side effects remain.
- Flush and push never coincide (single bus); no simultaneous push/pop case exists.

## Configuration
- WB_FIFO_RTY_EN defined: push when full and pop when empty terminate with wb_rty_o, no state change, stickies untouched.
- Undefined: push when full is dropped, acked, overflow sticky set; pop when empty acked with data 0, pointers unchanged, underflow sticky set.

## Test plan
- Reset, read 0x3004 -> ack, data 0x00010000 (empty, count 0); all outputs 0 during reset.
- Push 0xA1,0xB2,0xC3,0xD4 to 0x3000 back-to-back -> four consecutive acks; STATUS 0x00020004; pops return 0xA1..0xD4 in order, then STATUS 0x00010000.
- Push/pop 10 words alternating with depth 4 -> pointer wrap, each pop equals preceding push.
- Fifth push when full -> without macro: ack, STATUS 0x00060004; with WB_FIFO_RTY_EN: rty, STATUS 0x00020004. Pop empty -> ack data 0 + bit19 / rty.
- Access 0x300C, write 0x3004, sel 4'b0011 -> err, no state change; access 0x2000 -> no response from this block.
- Push 2 words, write 0x3 to 0x3008 -> ack; STATUS 0x00010000 with stickies cleared; assert reset in ack-pending cycle -> no ack emitted.
